logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the two-input seven-gate logic block.
- Applies one of seven bitwise operations (AND, OR, NOT, NAND, NOR, XOR, XNOR) to WIDTH-bit operands, selected per transaction by an opcode.
- Adds a two-stage elastic pipeline with valid/ready handshaking, result flags (zero, parity, illegal-op) and a transaction counter.
- Sits between an operand source and a result consumer in datapath exercises; both sides may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  in  1  clock, rising-edge
clrn  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept an operand transaction this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B (ignored for NOT)
op  in  3  opcode: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
f  out  WIDTH  result
zero  out  1  f == 0
parity  out  1  XOR-reduction of f
err  out  1  opcode was 7
count  out  CNT_W  number of results accepted by the consumer

Behaviour:
- Reset:
  - clrn low asynchronously clears both stage valid bits, f, zero, parity, err and count to 0.
  - in_ready reads 1 while reset is held, because it follows from the cleared stage-1 valid.
  - Transactions in flight at reset are discarded, not completed.
- Transfers:
  - Input transfer occurs on a rising edge with in_valid && in_ready.
  - Output transfer occurs on a rising edge with out_valid && out_ready.
- Stage 1 (S1): registers a, b, op.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready.
- Stage 2 (S2):
  - Computes the result from the S1 registers and registers f, zero, parity and err.
  - s2_ready = !s2_valid || out_ready.
  - out_valid = s2_valid.
- Latency and throughput: 2 cycles from input transfer to out_valid when unstalled; one transaction per cycle sustained.
  - The ready path is combinational from out_ready to in_ready by design; no skid buffer.
- Stall:
  - While out_valid && !out_ready, f, zero, parity and err hold stable.
  - S1 holds if it is also full; no data is lost or duplicated.
- Opcode 7: f = 0, zero = 1, parity = 0, err = 1. The transaction still flows and is counted.
- NOT: f = ~a; b is ignored.
- count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output transfers in the same cycle are legal; the pipeline stays full.
- Bubbles: in_valid low leaves S1 empty, and an empty stage drains downstream normally.
- Outputs are all registered except in_ready.
- No X is propagated: f, zero and parity are zero after reset until the first result.

Decomposition:
- Package logic_unit_pkg holds:
  - opcode localparams OP_AND..OP_XNOR, OP_ILL;
  - a function logic_op(a, b, op) returning the WIDTH-bit result, 0 for OP_ILL.
- Sub-module logic_unit_stage: one elastic register slice (valid, ready, data payload of parameterised width), instantiated for S1 and S2.
- The top level instantiates the two slices, calls the function between them, and holds the counter.

Test Plan:
- Reset then unstalled sweep: a=8'hC3, b=8'hA5, op 0..6 on consecutive cycles with out_ready=1.
  - Required f sequence: 81, E7, 3C, 7E, 18, 66, 99.
  - First out_valid 2 cycles after the first input transfer; count=7 at the end.
- Flags:
  - a=8'hFF, b=8'hFF, op=5 -> f=00, zero=1, parity=0.
  - a=8'h01, b=8'h00, op=1 -> f=01, zero=0, parity=1.
  - op=7 with any operands -> f=00, err=1, count increments.
- Backpressure:
  - Hold out_ready=0 while sending 3 transactions -> exactly 2 accepted, then in_ready=0, and f holds stable.
  - Release out_ready -> results emerge in order, none lost, none duplicated.
- Random valid/ready toggling for 1000 transactions -> output stream matches a scoreboard built from logic_op; count equals the number of output transfers.
- Reset mid-operation:
  - Pulse clrn low with both stages full -> out_valid=0, count=0 and in_ready=1 immediately (asynchronous).
  - No stale result appears after reset releases.
- Counter wrap with CNT_W=4 -> after 16 transfers count=0 and after 17 count=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared opcodes and the bitwise operation function used by logic_unit_pipe.
package logic_unit_pkg;

  localparam int unsigned OP_W     = 3;
  // Widest operand logic_op handles; callers narrow the result to their WIDTH.
  localparam int unsigned LU_MAX_W = 64;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

  function automatic logic [LU_MAX_W-1:0] logic_op(input logic [LU_MAX_W-1:0] a,
                                                   input logic [LU_MAX_W-1:0] b,
                                                   input logic [OP_W-1:0]     op);
    logic [LU_MAX_W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One elastic register slice: holds a payload until downstream accepts it.
module logic_unit_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Payload only moves on a real transfer so a stalled or drained slice keeps its data.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage elastic bitwise logic unit with result flags and a completed-transaction counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned S1_W = OP_W + 2 * WIDTH;
  localparam int unsigned S2_W = WIDTH + 3;

  logic             s1_valid, s2_ready;
  logic [S1_W-1:0]  s1_din, s1_dout;
  logic [S2_W-1:0]  s2_din, s2_dout;
  logic [WIDTH-1:0] s1_a, s1_b, f_c;
  logic [OP_W-1:0]  s1_op;
  logic [CNT_W-1:0] count_q, count_d;

  assign s1_din = {op, b, a};

  logic_unit_stage #(.DW(S1_W)) u_s1 (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_dout)
  );

  // Result and flags are formed between the slices and captured by S2.
  always_comb begin
    s1_a   = s1_dout[WIDTH-1:0];
    s1_b   = s1_dout[2*WIDTH-1:WIDTH];
    s1_op  = s1_dout[S1_W-1:2*WIDTH];
    f_c    = WIDTH'(logic_op(LU_MAX_W'(s1_a), LU_MAX_W'(s1_b), s1_op));
    s2_din = {(s1_op == OP_ILL), ^f_c, (f_c == '0), f_c};
  end

  logic_unit_stage #(.DW(S2_W)) u_s2 (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_dout)
  );

  assign f      = s2_dout[WIDTH-1:0];
  assign zero   = s2_dout[WIDTH];
  assign parity = s2_dout[WIDTH+1];
  assign err    = s2_dout[WIDTH+2];

  // Counts accepted results; wraps naturally at 2^CNT_W.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
